// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp drive and clear inputs plus decoded monitor status
interface traffic_light_monitor_if #(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 8
);
    logic               red;
    logic               amber;
    logic               green;
    logic               clear_fault;
    logic [2:0]         phase;
    logic [DWELL_W-1:0] dwell;
    logic               fault;
    logic [1:0]         fault_code;
    logic [CNT_W-1:0]   cycle_count;
    modport master (
        output red, amber, green, clear_fault,
        input  phase, dwell, fault, fault_code, cycle_count
    );
    modport slave (
        input  red, amber, green, clear_fault,
        output phase, dwell, fault, fault_code, cycle_count
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes lamp aspects, checks UK sequence and dwell, counts cycles
module traffic_light_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 200,
    parameter int DWELL_W   = 8,
    parameter int CNT_W     = 8
) (
    input logic                    clk,
    input logic                    rst,
    traffic_light_monitor_if.slave mon_io
);
    typedef enum logic [2:0] {
        UNKNOWN   = 3'd0,
        RED       = 3'd1,
        RED_AMBER = 3'd2,
        GREEN     = 3'd3,
        AMBER     = 3'd4
    } phase_e;

    localparam logic [DWELL_W-1:0] DWELL_SAT = {DWELL_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_OVR = DWELL_W'(MAX_DWELL + 1);

    phase_e             phase_q, phase_d, asp, succ;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic [1:0]         code_q, code_d;
    logic               c_illegal, c_seq, c_dwell;

    always_comb begin
        asp  = ({mon_io.red, mon_io.amber, mon_io.green} == 3'b100) ? RED :
               ({mon_io.red, mon_io.amber, mon_io.green} == 3'b110) ? RED_AMBER :
               ({mon_io.red, mon_io.amber, mon_io.green} == 3'b001) ? GREEN :
               ({mon_io.red, mon_io.amber, mon_io.green} == 3'b010) ? AMBER : UNKNOWN;
        succ = (phase_q == RED)       ? RED_AMBER :
               (phase_q == RED_AMBER) ? GREEN :
               (phase_q == GREEN)     ? AMBER : RED;
    end

    always_comb begin
        phase_d   = phase_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        c_illegal = 1'b0;
        c_seq     = 1'b0;
        c_dwell   = 1'b0;
        if (asp == UNKNOWN) begin
            phase_d   = UNKNOWN;
            dwell_d   = '0;
            c_illegal = 1'b1;
        end else if (phase_q == UNKNOWN) begin
            phase_d = asp;
            dwell_d = DWELL_W'(1);
        end else if (asp == phase_q) begin
            // saturation sits above MAX_DWELL+1, so the overrun fires once per occupancy
            dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + 1'b1;
            c_dwell = (dwell_d == DWELL_OVR);
        end else if (asp == succ) begin
            phase_d = asp;
            dwell_d = DWELL_W'(1);
            c_dwell = (dwell_q < DWELL_MIN);
            cnt_d   = (phase_q == AMBER && !c_dwell) ? cnt_q + 1'b1 : cnt_q;
        end else begin
            phase_d = asp;
            dwell_d = DWELL_W'(1);
            c_seq   = 1'b1;
        end
    end

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        if ((c_illegal || c_seq || c_dwell) && (!fault_q || mon_io.clear_fault)) begin
            fault_d = 1'b1;
            code_d  = c_illegal ? 2'd1 : c_seq ? 2'd2 : 2'd3;
        end else if (mon_io.clear_fault) begin
            fault_d = 1'b0;
            code_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= UNKNOWN;
            dwell_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign mon_io.phase       = phase_q;
    assign mon_io.dwell       = dwell_q;
    assign mon_io.fault       = fault_q;
    assign mon_io.fault_code  = code_q;
    assign mon_io.cycle_count = cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: table-driven checks on two parameterisations plus wrap/saturation runs
module tb_traffic_light_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [2:0] rag = 3'b000;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    traffic_light_monitor_if ma ();
    traffic_light_monitor_if #(.DWELL_W(8), .CNT_W(2)) mb ();

    assign {ma.red, ma.amber, ma.green} = rag;
    assign ma.clear_fault = clr;
    assign {mb.red, mb.amber, mb.green} = rag;
    assign mb.clear_fault = clr;

    traffic_light_monitor dut_a (.clk(clk), .rst(rst), .mon_io(ma));
    traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(5), .DWELL_W(8), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst), .mon_io(mb));

    typedef struct packed {
        logic       sel;
        logic       rst;
        logic       clr;
        logic [2:0] rag;
        logic [2:0] ph;
        logic [7:0] dw;
        logic       f;
        logic [1:0] fc;
        logic [7:0] cnt;
    } vec_t;

    vec_t q[$];

    task automatic add(input int s, input int r, input int c, input int a,
                       input int ph, input int dw, input int f, input int fc, input int cnt);
        vec_t v;
        v.sel = s[0];
        v.rst = r[0];
        v.clr = c[0];
        v.rag = a[2:0];
        v.ph  = ph[2:0];
        v.dw  = dw[7:0];
        v.f   = f[0];
        v.fc  = fc[1:0];
        v.cnt = cnt[7:0];
        q.push_back(v);
    endtask

    task automatic step(input logic r, input logic c, input logic [2:0] a);
        rst = r;
        clr = c;
        rag = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input logic s, input string tag, input int ph, input int dw,
                           input int f, input int fc, input int cnt);
        chk({tag, " phase"},       s ? int'(mb.phase)       : int'(ma.phase),       ph);
        chk({tag, " dwell"},       s ? int'(mb.dwell)       : int'(ma.dwell),       dw);
        chk({tag, " fault"},       s ? int'(mb.fault)       : int'(ma.fault),       f);
        chk({tag, " fault_code"},  s ? int'(mb.fault_code)  : int'(ma.fault_code),  fc);
        chk({tag, " cycle_count"}, s ? int'(mb.cycle_count) : int'(ma.cycle_count), cnt);
    endtask

    initial begin
        // dut_a: MIN_DWELL=1, MAX_DWELL=200, CNT_W=8
        add(0,1,0,4, 0,0,0,0,0);
        add(0,0,0,4, 1,1,0,0,0);
        add(0,0,0,4, 1,2,0,0,0);
        add(0,0,0,6, 2,1,0,0,0);
        add(0,0,0,6, 2,2,0,0,0);
        add(0,0,0,1, 3,1,0,0,0);
        add(0,0,0,1, 3,2,0,0,0);
        add(0,0,0,2, 4,1,0,0,0);
        add(0,0,0,2, 4,2,0,0,0);
        add(0,0,0,4, 1,1,0,0,1);
        add(0,0,0,4, 1,2,0,0,1);
        add(0,0,0,4, 1,3,0,0,1);
        add(0,0,0,5, 0,0,1,1,1);
        add(0,0,0,1, 3,1,1,1,1);
        add(0,0,0,4, 1,1,1,1,1);
        add(0,0,1,4, 1,2,0,0,1);
        add(0,0,0,1, 3,1,1,2,1);
        add(0,0,1,2, 4,1,0,0,1);
        add(0,0,1,7, 0,0,1,1,1);
        add(0,0,0,1, 3,1,1,1,1);
        add(0,0,0,1, 3,2,1,1,1);
        add(0,1,1,1, 0,0,0,0,0);
        add(0,0,0,1, 3,1,0,0,0);
        add(0,0,0,0, 0,0,1,1,0);
        add(0,0,0,4, 1,1,1,1,0);
        add(0,0,0,6, 2,1,1,1,0);
        add(0,0,0,1, 3,1,1,1,0);
        add(0,0,0,2, 4,1,1,1,0);
        add(0,0,0,4, 1,1,1,1,1);
        // dut_b: MIN_DWELL=3, MAX_DWELL=5, CNT_W=2
        add(1,1,0,4, 0,0,0,0,0);
        add(1,0,0,4, 1,1,0,0,0);
        add(1,0,0,4, 1,2,0,0,0);
        add(1,0,0,6, 2,1,1,3,0);
        add(1,0,1,6, 2,2,0,0,0);
        add(1,0,0,6, 2,3,0,0,0);
        add(1,0,0,1, 3,1,0,0,0);
        add(1,0,0,1, 3,2,0,0,0);
        add(1,0,0,1, 3,3,0,0,0);
        add(1,0,0,1, 3,4,0,0,0);
        add(1,0,0,1, 3,5,0,0,0);
        add(1,0,0,1, 3,6,1,3,0);
        add(1,0,0,1, 3,7,1,3,0);
        add(1,0,1,1, 3,8,0,0,0);
        add(1,0,0,1, 3,9,0,0,0);
        add(1,0,0,2, 4,1,0,0,0);
        add(1,0,0,4, 1,1,1,3,0);
        add(1,0,1,4, 1,2,0,0,0);
        add(1,0,0,4, 1,3,0,0,0);
        add(1,0,0,6, 2,1,0,0,0);
        foreach (q[i]) begin
            step(q[i].rst, q[i].clr, q[i].rag);
            chk_all(q[i].sel, $sformatf("row%0d", i), int'(q[i].ph), int'(q[i].dw),
                    int'(q[i].f), int'(q[i].fc), int'(q[i].cnt));
        end
        // cycle counter wrap on the 2-bit counter
        step(1'b1, 1'b0, 3'b100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b100);
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 3'b110);
            for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 3'b001);
            for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 3'b010);
            step(1'b0, 1'b0, 3'b100);
            chk_all(1'b1, $sformatf("wrap%0d", k), 1, 1, 0, 0, k % 4);
            for (int j = 0; j < 2; j++) step(1'b0, 1'b0, 3'b100);
        end
        // MAX_DWELL boundary and dwell saturation on the default parameterisation
        step(1'b1, 1'b0, 3'b100);
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 1'b0, 3'b100);
            if (i == 1 || i == 200 || i == 201 || i == 202 || i == 255 || i == 300)
                chk_all(1'b0, $sformatf("hold%0d", i), 1, (i > 255) ? 255 : i,
                        (i >= 201) ? 1 : 0, (i >= 201) ? 3 : 0, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
